// File: rtl/execute_stage_pipe_if.sv
// ID/EX to EX/MEM bundle for the execute stage: decoded instruction fields in,
// registered EX/MEM results and the stall back to the issuing stage out.
interface execute_stage_pipe_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
);
  logic               valid_i;
  logic [3:0]         alu_op_i;
  logic [NB_DATA-1:0] data_ra_i;
  logic [NB_DATA-1:0] data_rb_i;
  logic [NB_DATA-1:0] inmediate_i;
  logic               tipeI_i;
  logic [1:0]         fwd_a_sel_i;
  logic [1:0]         fwd_b_sel_i;
  logic [NB_DATA-1:0] mem_wb_data_i;
  logic [NB_REG-1:0]  wire_RW;
  logic [NB_REG-1:0]  wire_B;
  logic [1:0]         regDest_signal_i;
  logic               reg_write_i;

  logic               stall_o;
  logic               ex_valid_o;
  logic               reg_write_o;
  logic [NB_REG-1:0]  writeReg_o;
  logic [NB_DATA-1:0] alu_result_o;

  modport master (
    output valid_i, alu_op_i, data_ra_i, data_rb_i, inmediate_i, tipeI_i,
           fwd_a_sel_i, fwd_b_sel_i, mem_wb_data_i, wire_RW, wire_B,
           regDest_signal_i, reg_write_i,
    input  stall_o, ex_valid_o, reg_write_o, writeReg_o, alu_result_o
  );

  modport slave (
    input  valid_i, alu_op_i, data_ra_i, data_rb_i, inmediate_i, tipeI_i,
           fwd_a_sel_i, fwd_b_sel_i, mem_wb_data_i, wire_RW, wire_B,
           regDest_signal_i, reg_write_i,
    output stall_o, ex_valid_o, reg_write_o, writeReg_o, alu_result_o
  );
endinterface

// File: rtl/execute_stage_pipe.sv
// Execute stage: forwarding muxes, single-cycle ALU, and an iterative unsigned
// multiply/divide unit writing HI/LO while the stage stalls upstream.
module execute_stage_pipe #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  execute_stage_pipe_if.slave  ex
);

  localparam int NB_SH  = $clog2(NB_DATA);
  localparam int NB_CNT = $clog2(NB_DATA);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_LUI   = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg;
  logic [NB_CNT-1:0]   count_reg;
  logic [NB_DATA-1:0]  hi_reg;
  logic [NB_DATA-1:0]  lo_reg;
  logic [NB_DATA-1:0]  work_hi_reg;
  logic [NB_DATA-1:0]  work_lo_reg;
  logic [NB_DATA-1:0]  op_b_reg;
  logic                is_div_reg;

  logic                ex_valid_reg;
  logic                reg_write_reg;
  logic [NB_REG-1:0]   write_reg_reg;
  logic [NB_DATA-1:0]  alu_result_reg;

  logic [NB_DATA-1:0]  operand_a;
  logic [NB_DATA-1:0]  fwd_b;
  logic [NB_DATA-1:0]  operand_b;
  logic [NB_SH-1:0]    shamt;
  logic                accept;
  logic                is_iter_op;
  logic                single_accept;
  logic [NB_DATA-1:0]  alu_next;
  logic [NB_REG-1:0]   dest_next;

  logic [NB_DATA:0]    mul_sum;
  logic [NB_DATA:0]    div_shifted;
  logic [NB_DATA:0]    div_diff;
  logic                div_ge;
  logic [NB_DATA-1:0]  step_hi;
  logic [NB_DATA-1:0]  step_lo;

  // Forwarding: 01 feeds back this stage's own registered result.
  always_comb begin
    case (ex.fwd_a_sel_i)
      2'b01:   operand_a = alu_result_reg;
      2'b10:   operand_a = ex.mem_wb_data_i;
      default: operand_a = ex.data_ra_i;
    endcase
    case (ex.fwd_b_sel_i)
      2'b01:   fwd_b = alu_result_reg;
      2'b10:   fwd_b = ex.mem_wb_data_i;
      default: fwd_b = ex.data_rb_i;
    endcase
    operand_b = ex.tipeI_i ? ex.inmediate_i : fwd_b;
  end

  assign shamt         = operand_a[NB_SH-1:0];
  assign accept        = ex.valid_i && (state_reg == IDLE);
  assign is_iter_op    = (ex.alu_op_i == OP_MULTU) || (ex.alu_op_i == OP_DIVU);
  assign single_accept = accept && !is_iter_op;

  always_comb begin
    alu_next = '0;
    case (ex.alu_op_i)
      OP_ADD:  alu_next = operand_a + operand_b;
      OP_SUB:  alu_next = operand_a - operand_b;
      OP_AND:  alu_next = operand_a & operand_b;
      OP_OR:   alu_next = operand_a | operand_b;
      OP_XOR:  alu_next = operand_a ^ operand_b;
      OP_NOR:  alu_next = ~(operand_a | operand_b);
      OP_SLT:  alu_next = {{(NB_DATA-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: alu_next = {{(NB_DATA-1){1'b0}}, (operand_a < operand_b)};
      OP_SLL:  alu_next = operand_b << shamt;
      OP_SRL:  alu_next = operand_b >> shamt;
      OP_SRA:  alu_next = NB_DATA'($signed(operand_b) >>> shamt);
      OP_LUI:  alu_next = operand_b << (NB_DATA / 2);
      OP_MFHI: alu_next = hi_reg;
      OP_MFLO: alu_next = lo_reg;
      default: alu_next = '0;
    endcase
  end

  always_comb begin
    case (ex.regDest_signal_i)
      2'b01:   dest_next = ex.wire_RW;
      2'b10:   dest_next = NB_REG'(31);
      default: dest_next = ex.wire_B;
    endcase
  end

  // One radix-2 step. Multiply: shift-add with the multiplier in work_lo.
  // Divide: restoring, remainder in work_hi, quotient shifting into work_lo.
  // A zero divisor always "fits", giving an all-ones quotient and remainder A.
  always_comb begin
    mul_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, op_b_reg} : '0);
    div_shifted = {work_hi_reg, work_lo_reg[NB_DATA-1]};
    div_ge      = (div_shifted >= {1'b0, op_b_reg});
    div_diff    = div_shifted - {1'b0, op_b_reg};
    if (is_div_reg) begin
      step_hi = div_ge ? div_diff[NB_DATA-1:0] : div_shifted[NB_DATA-1:0];
      step_lo = {work_lo_reg[NB_DATA-2:0], div_ge};
    end else begin
      step_hi = mul_sum[NB_DATA:1];
      step_lo = {mul_sum[0], work_lo_reg[NB_DATA-1:1]};
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      work_hi_reg    <= '0;
      work_lo_reg    <= '0;
      op_b_reg       <= '0;
      is_div_reg     <= 1'b0;
      ex_valid_reg   <= 1'b0;
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      alu_result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && is_iter_op) begin
            state_reg   <= BUSY;
            count_reg   <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= operand_a;
            op_b_reg    <= operand_b;
            is_div_reg  <= (ex.alu_op_i == OP_DIVU);
          end
        end
        BUSY: begin
          work_hi_reg <= step_hi;
          work_lo_reg <= step_lo;
          count_reg   <= count_reg + 1'b1;
          if (count_reg == CNT_LAST) begin
            hi_reg    <= step_hi;
            lo_reg    <= step_lo;
            count_reg <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      ex_valid_reg  <= single_accept;
      reg_write_reg <= single_accept && ex.reg_write_i;
      if (single_accept) begin
        alu_result_reg <= alu_next;
        write_reg_reg  <= dest_next;
      end
    end
  end

  assign ex.stall_o      = (state_reg == BUSY);
  assign ex.ex_valid_o   = ex_valid_reg;
  assign ex.reg_write_o  = reg_write_reg;
  assign ex.writeReg_o   = write_reg_reg;
  assign ex.alu_result_o = alu_result_reg;

endmodule

// File: doc/execute_stage_pipe.md
EXECUTE_STAGE_PIPE -- requirements
Module: execute_stage_pipe

Interface
REQ-001 Parameter: NB_DATA, 32, operand/result width (even, >=8).
REQ-002 Parameter: NB_REG, 5, register-index width.
REQ-003 Port: clock_i  in  1  rising-edge clock; the block has one clock.
REQ-004 Port: reset_i  in  1  reset, asynchronous, active-high.
REQ-005 Port: valid_i  in  1  ID/EX instruction present.
REQ-006 Port: alu_op_i  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 MULTU, 13 DIVU, 14 MFHI, 15 MFLO.
REQ-007 Port: data_ra_i, data_rb_i  in  NB_DATA  register-file operands A, B.
REQ-008 Port: inmediate_i  in  NB_DATA  sign/zero-extended immediate.
REQ-009 Port: tipeI_i  in  1  1 = B operand is inmediate_i.
REQ-010 Port: fwd_a_sel_i, fwd_b_sel_i  in  2  00 register file, 01 own EX/MEM result, 10 mem_wb_data_i, 11 register file.
REQ-011 Port: mem_wb_data_i  in  NB_DATA  MEM/WB writeback value.
REQ-012 Port: wire_RW, wire_B  in  NB_REG  rd and rt indices.
REQ-013 Port: regDest_signal_i  in  2  00 rt, 01 rd, 10 constant 31, 11 rt.
REQ-014 Port: reg_write_i  in  1  instruction writes a register.
REQ-015 Port: stall_o  out  1  1 = instruction on inputs not accepted this cycle.
REQ-016 Port: ex_valid_o, reg_write_o  out  1  registered EX/MEM valid and write enable.
REQ-017 Port: writeReg_o  out  NB_REG  registered destination index.
REQ-018 Port: alu_result_o  out  NB_DATA  registered result.

Function
REQ-019 Operand A = forward-mux(fwd_a_sel_i); operand B = inmediate_i when tipeI_i, else forward-mux(fwd_b_sel_i); the 01 source is alu_result_o.
REQ-020 Ops 0-5: modulo-2^NB_DATA arithmetic/bitwise; SLT signed, SLTU unsigned, result 1 or 0.
REQ-021 SLL/SRL/SRA: shift B by A[log2(NB_DATA)-1:0]; LUI: B << (NB_DATA/2).
REQ-022 Single-cycle ops: accepted when valid_i and stall_o low; outputs update at the next edge (latency 1); ex_valid_o=1, reg_write_o=reg_write_i.
REQ-023 Cycles with no acceptance load ex_valid_o=0, reg_write_o=0; alu_result_o and writeReg_o hold.
REQ-024 MULTU/DIVU accepted: unsigned iterative unit starts, ex_valid_o=0, reg_write_o=0 (no writeback).
REQ-025 State machine IDLE -> BUSY on MULTU/DIVU acceptance; BUSY counts exactly NB_DATA cycles, then HI/LO are written and returns to IDLE on the same edge.
REQ-026 stall_o = (state == BUSY), combinational; any valid_i during BUSY is ignored and must be held upstream.
REQ-027 MULTU: {HI,LO} = A*B (2*NB_DATA bits). DIVU: LO = A/B, HI = A%B.
REQ-028 DIVU with B=0: LO = all ones, HI = A, same latency, no error flag.
REQ-029 MFHI/MFLO: result = HI or LO, single-cycle; issued right after the unit completes, they see the new HI/LO value.
REQ-030 Operands for MULTU/DIVU are captured at acceptance; later input changes do not affect the result.

Reset
REQ-031 reset_i high: immediately force state IDLE, counter 0, HI=LO=0, ex_valid_o=0, reg_write_o=0, alu_result_o=0, writeReg_o=0, stall_o=0.
REQ-032 Reset during BUSY aborts the operation; HI/LO are not updated with partial results.

Verification
REQ-033 ADD, A=0x7FFFFFFF, B=1, rd=9, regDest=01 -> next cycle alu_result_o=0x80000000, writeReg_o=9, ex_valid_o=1.
REQ-034 Back-to-back: ADD 5+3, then SUB with fwd_a_sel=01, B=2 -> second result 6.
REQ-035 MULTU 0xFFFFFFFF*2 -> stall_o high 32 cycles; MFHI then gives 1 and MFLO gives 0xFFFFFFFE.
REQ-036 DIVU 100/7 -> HI=2, LO=14. DIVU 9/0 -> HI=9, LO=0xFFFFFFFF.
REQ-037 Assert reset_i at BUSY cycle 10 of DIVU -> all outputs 0 immediately; then MFLO -> 0.
REQ-038 SRA B=0x80000000 by A=4 -> 0xF8000000; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
